// File: rtl/rpsc_interlock_seq_pkg.sv
// ---------------------------------------------------------------------------
// rpsc_pkg
// Shared types and constants for the power-supply interlock sequencer.
//   rpsc_state_t : per-channel state encoding (IDLE/QUAL/OK/TRIP)
//   cause_uv()   : cause code reported for an undervoltage trip
//   cause_none() : cause code after a trip has been acknowledged
//   TGT_2S/4S    : timer targets for the 1.28 us system clock
// ---------------------------------------------------------------------------
package rpsc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    QUAL = 2'd1,
    OK   = 2'd2,
    TRIP = 2'd3
  } rpsc_state_t;

  localparam int TGT_2S = 1562500;
  localparam int TGT_4S = 3125000;

  // Fault bits occupy codes 0..num_fault-1; UV and "none" sit just above.
  function automatic int cause_uv(input int num_fault);
    return num_fault;
  endfunction

  function automatic int cause_none(input int num_fault);
    return num_fault + 1;
  endfunction

endpackage

// File: rtl/rpsc_interlock_seq_if.sv
// ---------------------------------------------------------------------------
// rpsc_interlock_seq_if
// Discrete interlock inputs and PS enable/status outputs of all channels.
//   fault_i/fault_mask_i : NUM_CH*NUM_FAULT raw faults and ignore mask
//   ps_act_i/uv_i/ack_i  : per-channel request, undervoltage, trip ack
//   qual_tgt_i           : NUM_CH*TMR_W qualification cycle counts
//   alarm_n_o, on_perm_o, ch_ok_o, trip_o, state_o, cause_o : status
// slave = sequencer side, master = driver of the interlock inputs.
// ---------------------------------------------------------------------------
interface rpsc_interlock_seq_if #(
  parameter int NUM_CH    = 2,
  parameter int NUM_FAULT = 8,
  parameter int TMR_W     = 22,
  parameter int CAUSE_W   = $clog2(NUM_FAULT + 2)
);
  logic [NUM_CH*NUM_FAULT-1:0] fault_i;
  logic [NUM_CH*NUM_FAULT-1:0] fault_mask_i;
  logic [NUM_CH-1:0]           ps_act_i;
  logic [NUM_CH-1:0]           uv_i;
  logic [NUM_CH-1:0]           ack_i;
  logic [NUM_CH*TMR_W-1:0]     qual_tgt_i;
  logic [NUM_CH-1:0]           alarm_n_o;
  logic [NUM_CH-1:0]           on_perm_o;
  logic [NUM_CH-1:0]           ch_ok_o;
  logic [NUM_CH-1:0]           trip_o;
  logic [NUM_CH*2-1:0]         state_o;
  logic [NUM_CH*CAUSE_W-1:0]   cause_o;

  modport slave (
    input  fault_i, fault_mask_i, ps_act_i, uv_i, ack_i, qual_tgt_i,
    output alarm_n_o, on_perm_o, ch_ok_o, trip_o, state_o, cause_o
  );

  modport master (
    output fault_i, fault_mask_i, ps_act_i, uv_i, ack_i, qual_tgt_i,
    input  alarm_n_o, on_perm_o, ch_ok_o, trip_o, state_o, cause_o
  );
endinterface

// File: rtl/rpsc_interlock_seq_ch_fsm.sv
// ---------------------------------------------------------------------------
// rpsc_ch_fsm
// One interlock channel: request qualification, undervoltage watch, trip
// latch with first-fault cause.
//   clk, reset       : system clock, async active-low reset
//   fault_i/mask_i   : NUM_FAULT raw fault bits and ignore mask
//   ps_act_i, uv_i   : supply-active request, undervoltage (1 = low)
//   ack_i            : trip acknowledge (level)
//   qual_tgt_i       : qualification cycles (0 behaves as 1)
//   chain_ok_i       : upstream channel is OK
//   alarm_n_o        : ~fault_act, combinational
//   on_perm_o        : registered permit
//   state_o, cause_o : current state, latched cause
//
// state | meaning
// IDLE  | waiting for permit & request
// QUAL  | counting qualification cycles
// OK    | supply on; counter tracks consecutive UV cycles
// TRIP  | latched fault; needs ack with fault and request both gone
// ---------------------------------------------------------------------------
module rpsc_ch_fsm
  import rpsc_pkg::*;
#(
  parameter int NUM_FAULT    = 8,
  parameter int TMR_W        = 22,
  parameter int UV_CYC       = 3125000,
  parameter bit LATCH_FAULTS = 1'b1,
  parameter int CAUSE_W      = $clog2(NUM_FAULT + 2)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_FAULT-1:0] fault_i,
  input  logic [NUM_FAULT-1:0] fault_mask_i,
  input  logic                 ps_act_i,
  input  logic                 uv_i,
  input  logic                 ack_i,
  input  logic [TMR_W-1:0]     qual_tgt_i,
  input  logic                 chain_ok_i,
  output logic                 alarm_n_o,
  output logic                 on_perm_o,
  output rpsc_state_t          state_o,
  output logic [CAUSE_W-1:0]   cause_o
);

  localparam logic [TMR_W-1:0]   UV_LAST    = TMR_W'(UV_CYC - 1);
  localparam logic [CAUSE_W-1:0] CODE_UV    = CAUSE_W'(cause_uv(NUM_FAULT));
  localparam logic [CAUSE_W-1:0] CODE_NONE  = CAUSE_W'(cause_none(NUM_FAULT));

  rpsc_state_t          state_q, state_d;
  logic [TMR_W-1:0]     cnt_q, cnt_d;
  logic [CAUSE_W-1:0]   cause_q, cause_d;
  logic                 on_perm_q;

  logic [NUM_FAULT-1:0] fault_vec;
  logic                 fault_act;
  logic                 permit;
  logic [TMR_W-1:0]     qual_last;
  logic [TMR_W-1:0]     cnt_inc;
  logic [CAUSE_W-1:0]   fault_code;

  assign fault_vec = fault_i & ~fault_mask_i;
  assign fault_act = |fault_vec;
  assign permit    = ~fault_act & chain_ok_i & (state_q != TRIP);
  assign qual_last = (qual_tgt_i == '0) ? '0 : qual_tgt_i - TMR_W'(1);
  assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + TMR_W'(1);

  // Scan from the top down so the lowest active index is the last write.
  always_comb begin
    fault_code = CODE_UV;
    for (int i = NUM_FAULT - 1; i >= 0; i--) begin
      if (fault_vec[i]) fault_code = CAUSE_W'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    case (state_q)
      IDLE: begin
        if (permit && ps_act_i) begin
          state_d = QUAL;
          cnt_d   = '0;
        end
      end
      QUAL, OK: begin
        if (fault_act) begin
          cnt_d = '0;
          if (LATCH_FAULTS) begin
            state_d = TRIP;
            cause_d = fault_code;
          end else begin
            state_d = IDLE;
          end
        end else if (!ps_act_i || !chain_ok_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (state_q == QUAL) begin
          if (cnt_q == qual_last) begin
            state_d = OK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end else if (uv_i) begin
          if (cnt_q == UV_LAST) begin
            state_d = TRIP;
            cause_d = CODE_UV;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end else begin
          cnt_d = '0;
        end
      end
      TRIP: begin
        if (ack_i && !fault_act && !ps_act_i) begin
          state_d = IDLE;
          cause_d = CODE_NONE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      cause_q   <= '0;
      on_perm_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cause_q   <= cause_d;
      on_perm_q <= permit;
    end
  end

  assign alarm_n_o = ~fault_act;
  assign on_perm_o = on_perm_q;
  assign state_o   = state_q;
  assign cause_o   = cause_q;

endmodule

// File: rtl/rpsc_interlock_seq.sv
// ---------------------------------------------------------------------------
// rpsc_interlock_seq
// Multi-channel PS interlock sequencer. Channel c may only start or stay on
// while channel c-1 is OK (grid-then-anode chain).
//   clk   : system clock
//   reset : async active-low reset
//   bus   : interlock inputs and PS status outputs (slave modport)
// ---------------------------------------------------------------------------
module rpsc_interlock_seq
  import rpsc_pkg::*;
#(
  parameter int NUM_CH       = 2,
  parameter int NUM_FAULT    = 8,
  parameter int TMR_W        = 22,
  parameter int UV_CYC       = 3125000,
  parameter bit LATCH_FAULTS = 1'b1,
  parameter int CAUSE_W      = $clog2(NUM_FAULT + 2)
) (
  input  logic                 clk,
  input  logic                 reset,
  rpsc_interlock_seq_if.slave  bus
);

  rpsc_state_t st [NUM_CH];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic chain_ok;

    if (c == 0) begin : g_head
      assign chain_ok = 1'b1;
    end else begin : g_link
      assign chain_ok = (st[c-1] == OK);
    end

    rpsc_ch_fsm #(
      .NUM_FAULT    (NUM_FAULT),
      .TMR_W        (TMR_W),
      .UV_CYC       (UV_CYC),
      .LATCH_FAULTS (LATCH_FAULTS),
      .CAUSE_W      (CAUSE_W)
    ) u_ch (
      .clk          (clk),
      .reset        (reset),
      .fault_i      (bus.fault_i[c*NUM_FAULT +: NUM_FAULT]),
      .fault_mask_i (bus.fault_mask_i[c*NUM_FAULT +: NUM_FAULT]),
      .ps_act_i     (bus.ps_act_i[c]),
      .uv_i         (bus.uv_i[c]),
      .ack_i        (bus.ack_i[c]),
      .qual_tgt_i   (bus.qual_tgt_i[c*TMR_W +: TMR_W]),
      .chain_ok_i   (chain_ok),
      .alarm_n_o    (bus.alarm_n_o[c]),
      .on_perm_o    (bus.on_perm_o[c]),
      .state_o      (st[c]),
      .cause_o      (bus.cause_o[c*CAUSE_W +: CAUSE_W])
    );

    assign bus.ch_ok_o[c]          = (st[c] == OK);
    assign bus.trip_o[c]           = (st[c] == TRIP);
    assign bus.state_o[2*c +: 2]   = st[c];
  end

endmodule

// File: doc/rpsc_interlock_seq.md
Name: rpsc_interlock_seq

Overview:
- Parametrised multi-channel power-supply interlock sequencer; the generalised successor of the per-card grid/anode permit logic.
- Each channel qualifies its supply-active request for a programmable time, then monitors undervoltage, and latches trips with a first-fault cause until acknowledged.
- Channel c is permitted only while channel c-1 is OK; this forms the grid-then-anode dependency chain.
- Sits between the discrete interlock inputs and the PS enable/status outputs.

Parameters:
- NUM_CH, 2, number of chained channels (>=1).
- NUM_FAULT, 8, fault inputs per channel.
- TMR_W, 22, qualification/UV counter width.
- UV_CYC, 3125000, consecutive undervoltage cycles in OK before trip (4 s at 1.28 us).
- LATCH_FAULTS, 1, 1 = faults latch TRIP; 0 = faults return the channel to IDLE.
- CAUSE_W, $clog2(NUM_FAULT+2), cause code width.

Ports:
- clk, in, 1, system clock.
- reset, in, 1, asynchronous active-low reset.
- fault_i, in, NUM_CH*NUM_FAULT, raw fault bits (1 = fault); channel c occupies [c*NUM_FAULT +: NUM_FAULT].
- fault_mask_i, in, NUM_CH*NUM_FAULT, 1 = ignore the bit.
- ps_act_i, in, NUM_CH, supply-active request per channel.
- uv_i, in, NUM_CH, undervoltage monitor (1 = low).
- ack_i, in, NUM_CH, trip acknowledge; level-sampled.
- qual_tgt_i, in, NUM_CH*TMR_W, qualification cycles per channel (0 treated as 1).
- alarm_n_o, out, NUM_CH, ~fault_act; combinational.
- on_perm_o, out, NUM_CH, registered permit.
- ch_ok_o, out, NUM_CH, state==OK.
- trip_o, out, NUM_CH, state==TRIP.
- state_o, out, NUM_CH*2, state encoding.
- cause_o, out, NUM_CH*CAUSE_W, latched first-fault cause.

Behaviour:
- fault_act[c] = |(fault_i[c] & ~fault_mask_i[c]).
- chain_ok[0] = 1; chain_ok[c] = (state[c-1]==OK) for c>0.
- permit[c] = ~fault_act[c] & chain_ok[c] & (state[c]!=TRIP).
- on_perm_o = permit registered one cycle.
- Reset (async, reset=0), all channels:
  - state = IDLE, counter = 0, cause = 0.
  - on_perm_o, ch_ok_o, trip_o = 0.
  - alarm_n_o follows inputs even during reset.
- States: IDLE=0, QUAL=1, OK=2, TRIP=3.
- Same-cycle priority: fault > ps_act drop > chain loss > undervoltage expiry > qualification completion.
- IDLE:
  - If permit & ps_act: go to QUAL, counter = 0.
  - A fault in IDLE blocks entry but never latches.
- QUAL:
  - Counter +1 per cycle.
  - When counter == max(tgt,1)-1: go to OK. ch_ok_o therefore rises exactly max(tgt,1) cycles after the QUAL entry edge.
  - ps_act low or chain loss: go to IDLE, counter cleared.
  - Fault: TRIP if LATCH_FAULTS=1, else IDLE.
- OK:
  - Counter is reused as the UV counter: +1 while uv_i=1, cleared when uv_i=0.
  - Count reaching UV_CYC-1 with uv_i still 1: go to TRIP, cause = NUM_FAULT.
  - ps_act low or chain loss: go to IDLE, no trip. Downstream channels then drop to IDLE through chain_ok.
  - Fault: TRIP or IDLE per LATCH_FAULTS.
- Counter saturates at all-ones and never wraps.
- TRIP:
  - Exit to IDLE only when ack_i=1 & ~fault_act & ~ps_act_i in the same cycle. Otherwise hold.
  - ack_i while a fault persists is ignored; it is not remembered.
- Cause latching:
  - Cause is captured only on entry to TRIP: lowest-index active unmasked fault bit, else NUM_FAULT (UV).
  - Cause holds through TRIP and is cleared to NUM_FAULT+1 (none) on the TRIP->IDLE exit.
  - Reset value is 0.
- Simultaneous faults: the lowest index wins.
- Fault mask changes take effect in the same cycle.
- Reset mid-QUAL/OK/TRIP forces IDLE immediately; latched cause is lost.

Decomposition:
- Package rpsc_pkg holds:
  - Enum rpsc_state_t {IDLE, QUAL, OK, TRIP} (2-bit).
  - Cause constants CAUSE_UV = NUM_FAULT and CAUSE_NONE = NUM_FAULT+1, as functions of NUM_FAULT.
  - Default timer targets for the 1.28 us clock: 2 s = 1562500, 4 s = 3125000.
- One sub-module, rpsc_ch_fsm: single-channel FSM, counter and cause encoder. It takes chain_ok_i and exports state.
- Top generates NUM_CH instances and wires the chain.

Test Plan (NUM_CH=2, NUM_FAULT=4, TMR_W=4, UV_CYC=15, qual_tgt=8/8):
- Release reset, all faults 0, set ps_act=01 → ch_ok_o[0] rises exactly 8 cycles after the QUAL entry; channel 1 stays IDLE. Then set ps_act=11 → ch_ok_o[1] rises 8 cycles later.
- Both channels OK, raise fault_i[0] bit2 → next cycle state0=TRIP, cause0=2, alarm_n_o[0]=0 immediately; ch1 goes to IDLE the cycle after, with trip_o[1]=0.
- Channel 0 in TRIP with the fault still active, pulse ack → stays TRIP. Clear fault, drop ps_act[0], pulse ack → IDLE, cause0=5.
- Channel 0 in OK, uv_i[0]=1 for 14 cycles then 0 → stays OK. Then uv_i[0]=1 for 15 cycles → TRIP, cause0=4.
- Faults on bits 3 and 1 in the same cycle with mask bit1=1 → cause0=3. With LATCH_FAULTS=0 the same stimulus → IDLE, trip_o=0.
- Assert reset low mid-QUAL, counter=5 → state IDLE asynchronously; after release, ps_act high with qual_tgt=0 → OK after 1 cycle.
